// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - gate select codes, sequencer states and expected-output function
package gate_test_pkg;

  localparam logic [2:0] GATE_AND  = 3'b000;
  localparam logic [2:0] GATE_OR   = 3'b001;
  localparam logic [2:0] GATE_NAND = 3'b010;
  localparam logic [2:0] GATE_NOR  = 3'b011;
  localparam logic [2:0] GATE_XOR  = 3'b100;
  localparam logic [2:0] GATE_XNOR = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  function automatic logic sel_valid(input logic [2:0] sel);
    return sel <= GATE_XNOR;
  endfunction

  // Unknown codes return 0 so an invalid selection never looks like a match source.
  function automatic logic expected_out(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      GATE_AND:  return a & b;
      GATE_OR:   return a | b;
      GATE_NAND: return ~(a & b);
      GATE_NOR:  return ~(a | b);
      GATE_XOR:  return a ^ b;
      GATE_XNOR: return ~(a ^ b);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_expect.sv
// rtl/gate_expect.sv - combinational expected gate output for the current vector
module gate_expect
  import gate_test_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  assign y = expected_out(sel, a, b);

endmodule

// File: rtl/gate_test_seq.sv
// rtl/gate_test_seq.sv - exhaustive four-vector test sequencer for a socket of two-input gates
module gate_test_seq
  import gate_test_pkg::*;
#(
  parameter int NUM_GATES     = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           gate_sel,
  output logic [NUM_GATES-1:0] dut_a,
  output logic [NUM_GATES-1:0] dut_b,
  input  logic [NUM_GATES-1:0] dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] gate_pass,
  output logic                 invalid_sel
);

  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  state_t               state;
  logic [2:0]           sel_q;
  logic [1:0]           vec;
  logic [1:0]           vec_next;
  logic [CW-1:0]        cnt;
  logic [NUM_GATES-1:0] y_m;
  logic [NUM_GATES-1:0] y_s;
  logic                 exp_y;
  logic [NUM_GATES-1:0] pass_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_m <= '0;
      y_s <= '0;
    end else begin
      y_m <= dut_y;
      y_s <= y_m;
    end
  end

  gate_expect u_expect (
    .sel (sel_q),
    .a   (vec[1]),
    .b   (vec[0]),
    .y   (exp_y)
  );

  assign pass_next = gate_pass & ~(y_s ^ {NUM_GATES{exp_y}});
  assign vec_next  = vec + 2'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      sel_q       <= GATE_AND;
      vec         <= 2'd0;
      cnt         <= '0;
      dut_a       <= '0;
      dut_b       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      gate_pass   <= '0;
      invalid_sel <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pass <= 1'b0;
            if (sel_valid(gate_sel)) begin
              sel_q       <= gate_sel;
              vec         <= 2'd0;
              gate_pass   <= '1;
              invalid_sel <= 1'b0;
              busy        <= 1'b1;
              dut_a       <= '0;
              dut_b       <= '0;
              cnt         <= CNT_LOAD;
              state       <= ST_SETTLE;
            end else begin
              invalid_sel <= 1'b1;
              gate_pass   <= '0;
              done        <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        ST_SAMPLE: begin
          gate_pass <= pass_next;
          if (vec == 2'd3) begin
            // Outputs take their DONE values on entry so done and pass appear together.
            pass  <= &pass_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            dut_a <= '0;
            dut_b <= '0;
            state <= ST_DONE;
          end else begin
            vec   <= vec_next;
            dut_a <= {NUM_GATES{vec_next[1]}};
            dut_b <= {NUM_GATES{vec_next[0]}};
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_seq.sv
// tb/tb_gate_test_seq.sv - directed self-checking bench for gate_test_seq
module tb_gate_test_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] gate_sel = 3'b000;
  logic [2:0] model_sel = 3'b000;
  logic [3:0] stuck = 4'b0000;

  logic [3:0] dut_a, dut_b, dut_y, gate_pass;
  logic       busy, done, pass, invalid_sel;

  logic       b_start = 1'b0;
  logic [2:0] b_gate_sel = 3'b000;
  logic [5:0] b_dut_a, b_dut_b, b_dut_y, b_gate_pass;
  logic       b_busy, b_done, b_pass, b_invalid_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic model_fn(input logic [2:0] sel, input logic a, input logic b);
    case (sel)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~(a & b);
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    dut_y = '0;
    for (int i = 0; i < 4; i++)
      dut_y[i] = stuck[i] ? 1'b0 : model_fn(model_sel, dut_a[i], dut_b[i]);
  end

  always_comb begin
    b_dut_y = '0;
    for (int i = 0; i < 6; i++)
      b_dut_y[i] = model_fn(3'd5, b_dut_a[i], b_dut_b[i]);
  end

  gate_test_seq #(.NUM_GATES(4), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .gate_sel(gate_sel),
    .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y), .busy(busy), .done(done),
    .pass(pass), .gate_pass(gate_pass), .invalid_sel(invalid_sel)
  );

  gate_test_seq #(.NUM_GATES(6), .SETTLE_CYCLES(3)) u_dut6 (
    .clk(clk), .reset(reset), .start(b_start), .gate_sel(b_gate_sel),
    .dut_a(b_dut_a), .dut_b(b_dut_b), .dut_y(b_dut_y), .busy(b_busy), .done(b_done),
    .pass(b_pass), .gate_pass(b_gate_pass), .invalid_sel(b_invalid_sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a test on the 4-gate instance and watches 40 cycles; cycle k is the k-th cycle after edge 0.
  task automatic run(input logic [2:0] sel, input logic [3:0] stk, input bit inject,
                     output int dcyc, output int ndone, output logic busy1,
                     output logic [3:0] gp6, output logic [3:0] gp11, output logic [3:0] ab_seen);
    @(negedge clk);
    gate_sel = sel; model_sel = sel; stuck = stk; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcyc = -1; ndone = 0; busy1 = 1'b0; gp6 = '0; gp11 = '0; ab_seen = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
      if (c == 1) busy1 = busy;
      if (c == 6) gp6 = gate_pass;
      if (c == 11) gp11 = gate_pass;
      ab_seen = ab_seen | dut_a | dut_b;
      if (inject && c == 7) begin
        gate_sel = 3'd1;
        start = 1'b1;
      end
      if (inject && c == 8) start = 1'b0;
    end
  endtask

  int dcyc, ndone;
  logic busy1;
  logic [3:0] gp6, gp11, ab_seen;

  initial begin
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_gate_pass", 32'(gate_pass), 32'd0);
    chk("reset_ab", 32'({dut_a, dut_b}), 32'd0);
    chk("reset_pass_inv", 32'({pass, invalid_sel}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run(3'd2, 4'b0000, 1'b0, dcyc, ndone, busy1, gp6, gp11, ab_seen);
    chk("nand_done_cycle", 32'(dcyc), 32'd21);
    chk("nand_ndone", 32'(ndone), 32'd1);
    chk("nand_busy1", 32'(busy1), 32'd1);
    chk("nand_pass", 32'(pass), 32'd1);
    chk("nand_gate_pass", 32'(gate_pass), 32'hF);
    chk("nand_invalid", 32'(invalid_sel), 32'd0);
    chk("nand_idle_busy", 32'(busy), 32'd0);

    run(3'd4, 4'b0100, 1'b0, dcyc, ndone, busy1, gp6, gp11, ab_seen);
    chk("xor_done_cycle", 32'(dcyc), 32'd21);
    chk("xor_gp_after_v00", 32'(gp6), 32'hF);
    chk("xor_gp_after_v01", 32'(gp11), 32'hB);
    chk("xor_gate_pass", 32'(gate_pass), 32'hB);
    chk("xor_pass", 32'(pass), 32'd0);

    run(3'd6, 4'b0000, 1'b0, dcyc, ndone, busy1, gp6, gp11, ab_seen);
    chk("inv_done_cycle", 32'(dcyc), 32'd1);
    chk("inv_ndone", 32'(ndone), 32'd1);
    chk("inv_invalid", 32'(invalid_sel), 32'd1);
    chk("inv_pass", 32'(pass), 32'd0);
    chk("inv_gate_pass", 32'(gate_pass), 32'd0);
    chk("inv_ab_quiet", 32'(ab_seen), 32'd0);
    chk("inv_busy1", 32'(busy1), 32'd0);

    run(3'd0, 4'b0000, 1'b1, dcyc, ndone, busy1, gp6, gp11, ab_seen);
    chk("restart_done_cycle", 32'(dcyc), 32'd21);
    chk("restart_ndone", 32'(ndone), 32'd1);
    chk("restart_pass", 32'(pass), 32'd1);
    chk("restart_gate_pass", 32'(gate_pass), 32'hF);
    chk("restart_invalid_clr", 32'(invalid_sel), 32'd0);

    // OR test interrupted by reset while vector 2 (a=1, b=0) is driven.
    @(negedge clk);
    gate_sel = 3'd1; model_sel = 3'd1; stuck = 4'b0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(negedge clk);
    chk("or_v2_a", 32'(dut_a), 32'hF);
    chk("or_v2_b", 32'(dut_b), 32'h0);
    chk("or_v2_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_ab", 32'({dut_a, dut_b}), 32'd0);
    chk("rst_mid_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_mid_results", 32'({pass, invalid_sel, gate_pass}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid_no_done", 32'(ndone), 32'd0);
    chk("rst_mid_idle", 32'(busy), 32'd0);

    run(3'd0, 4'b0000, 1'b0, dcyc, ndone, busy1, gp6, gp11, ab_seen);
    chk("and_after_rst_cycle", 32'(dcyc), 32'd21);
    chk("and_after_rst_pass", 32'(pass), 32'd1);
    chk("and_after_rst_gp", 32'(gate_pass), 32'hF);

    @(negedge clk);
    b_gate_sel = 3'd5; b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    dcyc = -1; ndone = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (b_done) begin
        ndone++;
        if (dcyc < 0) dcyc = c;
      end
    end
    chk("xnor6_done_cycle", 32'(dcyc), 32'd17);
    chk("xnor6_ndone", 32'(ndone), 32'd1);
    chk("xnor6_gate_pass", 32'(b_gate_pass), 32'h3F);
    chk("xnor6_pass", 32'(b_pass), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
